uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001: Parameter CLKS_PER_BIT, default 868, meaning i_Clk cycles per bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002: i_Clk  input  1  system clock, all logic on rising edge.
REQ-003: i_Rst  input  1  reset, asynchronous, active-high.
REQ-004: i_RX  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005: o_Data  output  8  received byte; valid while o_Valid=1.
REQ-006: o_Valid  output  1  holding register contains an unconsumed byte.
REQ-007: i_Ready  input  1  consumer accepts o_Data in any cycle where o_Valid=1 and i_Ready=1.
REQ-008: o_FrameErr  output  1  one-cycle pulse: stop bit sampled low.
REQ-009: o_Overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.
REQ-010: o_Busy  output  1  high in any state other than IDLE.

Function
REQ-011: i_RX SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-012: FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013: IDLE: on rx_s=0, go to START and clear the bit counter.
REQ-014: START: after floor(CLKS_PER_BIT/2) cycles, sample rx_s; 0 -> DATA with counter restarted; 1 -> IDLE (glitch rejected, no flags).
REQ-015: DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit[n], n=0..7 LSB first; after bit 7 -> STOP.
REQ-016: STOP: after CLKS_PER_BIT cycles, sample rx_s; 1 -> byte complete, go to IDLE; 0 -> pulse o_FrameErr, discard byte, go to WAIT_IDLE.
REQ-017: WAIT_IDLE: remain until rx_s=1, then go to IDLE; a break (line held low) SHALL produce exactly one o_FrameErr.
REQ-018: Cycle counter SHALL be 16 bits wide and SHALL not wrap within a bit period.
REQ-019: Byte completion with o_Valid=0 SHALL load o_Data and set o_Valid on the next cycle.
REQ-020: Byte completion with o_Valid=1 and i_Ready=1 in the same cycle SHALL load the new byte, keep o_Valid=1, no overrun.
REQ-021: Byte completion with o_Valid=1 and i_Ready=0 SHALL retain the old byte, drop the new one, and pulse o_Overrun.
REQ-022: Handshake without completion (o_Valid=1, i_Ready=1) SHALL clear o_Valid next cycle; o_Data holds its last value.
REQ-023: i_Ready while o_Valid=0 SHALL have no effect.
REQ-024: Latency: o_Valid rises 2 (sync) + floor(CLKS_PER_BIT/2) + 9*CLKS_PER_BIT + 1 cycles after the start-bit falling edge at i_RX, +-1 cycle sync uncertainty.
REQ-025: A new start bit SHALL be detected starting from the first IDLE cycle after STOP (back-to-back frames supported with no idle gap).

Reset
REQ-026: i_Rst=1 SHALL immediately force state IDLE, counters 0, shift register 0, o_Data=0, o_Valid=0, o_FrameErr=0, o_Overrun=0, o_Busy=0; synchronizer flops reset to 1.
REQ-027: Reset mid-frame SHALL discard the partial byte; after release, the remainder of the interrupted frame SHALL not produce o_Valid unless a genuine falling edge begins a new frame.
REQ-028: Reset SHALL clear a pending unconsumed byte.

Verification (CLKS_PER_BIT=4, i_Ready=1 unless stated)
REQ-029: Send 0xA5, correct stop -> o_Data=0xA5, o_Valid 1 cycle, o_FrameErr=0, o_Overrun=0, rise time per REQ-024.
REQ-030: i_RX low for 1 cycle then high -> returns to IDLE, o_Valid/o_FrameErr stay 0, o_Busy drops within 5 cycles.
REQ-031: Send 0x3C with stop bit 0, then hold line low 30 cycles -> exactly one o_FrameErr pulse, no o_Valid; then 0x81 received correctly after line returns high.
REQ-032: i_Ready=0, send 0x11 then 0x22 back-to-back -> o_Data=0x11 retained, one o_Overrun pulse; assert i_Ready -> o_Valid clears next cycle.
REQ-033: i_Ready asserted exactly at 0x22's completion with 0x11 pending -> o_Data=0x22, o_Valid stays 1, no o_Overrun.
REQ-034: Assert i_Rst during DATA bit 4 of 0xFF -> all outputs 0 immediately; subsequent frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a single-entry
// holding register with ready/valid handshake, frame-error and overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_RX,
    input  logic       i_Ready,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    output logic       o_FrameErr,
    output logic       o_Overrun,
    output logic       o_Busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_e;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic        rx_meta_q;
    logic        rx_s_q;
    logic [1:0]  warm_q;
    logic        armed_q;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        frame_err_q;

    logic        byte_done;
    logic [7:0]  data_d, data_q;
    logic        valid_d, valid_q;
    logic        overrun_d, overrun_q;

    // Synchronizer resets to idle-high; armed_q blocks start detection after reset
    // until the line has been seen high through a fully refilled synchronizer.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            warm_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so each flop samples the pre-edge value of the one before it.
            rx_meta_q <= i_RX;
            rx_s_q    <= rx_meta_q;
            warm_q    <= {warm_q[0], 1'b1};
            if (warm_q[1] && rx_s_q) armed_q <= 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (armed_q && !rx_s_q) state_q <= START;
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        state_q <= rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_done = (state_q == STOP) && (cnt_q == BIT_LAST) && rx_s_q;

    // A completing byte may replace the held one only if the consumer takes it this cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && i_Ready) valid_d = 1'b0;
        if (byte_done) begin
            if (!valid_q || i_Ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_Data     = data_q;
    assign o_Valid    = valid_q;
    assign o_FrameErr = frame_err_q;
    assign o_Overrun  = overrun_q;
    assign o_Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, directed handshake/reset
// sequences and randomized frames checked against a frame-level reference model.
module tb_uart_rx;

    localparam int CPB     = 4;
    localparam int EXP_LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       i_Clk;
    logic       i_Rst;
    logic       i_RX;
    logic       i_Ready;
    logic [7:0] o_Data;
    logic       o_Valid;
    logic       o_FrameErr;
    logic       o_Overrun;
    logic       o_Busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_RX       (i_RX),
        .i_Ready    (i_Ready),
        .o_Data     (o_Data),
        .o_Valid    (o_Valid),
        .o_FrameErr (o_FrameErr),
        .o_Overrun  (o_Overrun),
        .o_Busy     (o_Busy)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int tests = 0;
    int fails = 0;

    int         cyc = 0;
    int         t_fall = 0;
    int         last_rise = 0;
    int         valid_cyc = 0;
    int         hs_cnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] last_hs = 8'h00;
    logic [7:0] got_q[$];

    always @(posedge i_Clk) cyc <= cyc + 1;

    always @(negedge i_Clk) begin
        valid_prev <= o_Valid;
        if (o_Valid) valid_cyc <= valid_cyc + 1;
        if (o_Valid && !valid_prev) last_rise <= cyc;
        if (o_Valid && i_Ready) begin
            hs_cnt  <= hs_cnt + 1;
            last_hs <= o_Data;
            got_q.push_back(o_Data);
        end
        if (o_FrameErr) ferr_cnt <= ferr_cnt + 1;
        if (o_Overrun)  ovr_cnt  <= ovr_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        i_RX = b;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        t_fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         post_low;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] exp_q[$];

    initial begin
        int v0, h0, f0, o0, lat, last_busy, rand_base, exp_ferr, n;
        logic seen_busy;
        logic [7:0] d;
        logic stop;

        vecs[0] = '{8'hA5, 1'b1, 0,  1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 0,  1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 0,  1, 0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b0, 30, 0, 1, 8'h00};
        vecs[4] = '{8'h81, 1'b1, 0,  1, 0, 8'h81};
        vecs[5] = '{8'h6E, 1'b0, 0,  0, 1, 8'h00};
        vecs[6] = '{8'h01, 1'b1, 0,  1, 0, 8'h01};

        i_Rst   = 1'b1;
        i_RX    = 1'b1;
        i_Ready = 1'b1;
        wait_cycles(3);
        check("reset o_Valid",    32'(o_Valid),    32'd0);
        check("reset o_Data",     32'(o_Data),     32'd0);
        check("reset o_Busy",     32'(o_Busy),     32'd0);
        check("reset o_FrameErr", 32'(o_FrameErr), 32'd0);
        check("reset o_Overrun",  32'(o_Overrun),  32'd0);
        i_Rst = 1'b0;
        wait_cycles(4);

        // Table-driven frames, consumer always ready.
        for (int k = 0; k < 7; k++) begin
            v0 = valid_cyc; f0 = ferr_cnt; o0 = ovr_cnt;
            send_frame(vecs[k].data, vecs[k].stop);
            if (vecs[k].post_low > 0) begin
                i_RX = 1'b0;
                wait_cycles(vecs[k].post_low);
            end
            i_RX = 1'b1;
            wait_cycles(3 * CPB);
            check($sformatf("vec%0d valid cycles", k), 32'(valid_cyc - v0), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d frame errors", k), 32'(ferr_cnt - f0), 32'(vecs[k].exp_ferr));
            check($sformatf("vec%0d overruns", k), 32'(ovr_cnt - o0), 32'd0);
            if (vecs[k].exp_valid != 0) begin
                lat = last_rise - t_fall;
                check($sformatf("vec%0d data", k), 32'(last_hs), 32'(vecs[k].exp_data));
                check($sformatf("vec%0d latency %0d", k, lat),
                      32'(lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 32'd1);
            end
        end

        // One-cycle glitch is rejected in START.
        v0 = valid_cyc; f0 = ferr_cnt;
        i_RX = 1'b0;
        wait_cycles(1);
        i_RX = 1'b1;
        seen_busy = 1'b0; last_busy = 0;
        for (int i = 1; i <= 10; i++) begin
            wait_cycles(1);
            if (o_Busy) begin
                seen_busy = 1'b1;
                last_busy = i;
            end
        end
        check("glitch busy seen", 32'(seen_busy), 32'd1);
        check("glitch busy drops within 5", 32'(last_busy <= 5), 32'd1);
        check("glitch valid", 32'(valid_cyc - v0), 32'd0);
        check("glitch frame error", 32'(ferr_cnt - f0), 32'd0);

        // Overrun: two back-to-back bytes with the consumer stalled.
        i_Ready = 1'b0;
        o0 = ovr_cnt; f0 = ferr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        i_RX = 1'b1;
        wait_cycles(3 * CPB);
        check("overrun o_Valid", 32'(o_Valid), 32'd1);
        check("overrun o_Data kept", 32'(o_Data), 32'h11);
        check("overrun pulses", 32'(ovr_cnt - o0), 32'd1);
        check("overrun frame errors", 32'(ferr_cnt - f0), 32'd0);
        i_Ready = 1'b1;
        wait_cycles(1);
        check("handshake clears o_Valid", 32'(o_Valid), 32'd0);
        check("handshake o_Data holds", 32'(o_Data), 32'h11);

        // Ready coincides with completion of the second byte.
        i_Ready = 1'b0;
        send_frame(8'h11, 1'b1);
        i_RX = 1'b1;
        wait_cycles(2 * CPB);
        check("pending o_Valid", 32'(o_Valid), 32'd1);
        o0 = ovr_cnt;
        send_frame(8'h22, 1'b1);
        i_Ready = 1'b1;
        i_RX    = 1'b1;
        wait_cycles(1);
        i_Ready = 1'b0;
        wait_cycles(2);
        check("replace o_Data", 32'(o_Data), 32'h22);
        check("replace o_Valid", 32'(o_Valid), 32'd1);
        check("replace no overrun", 32'(ovr_cnt - o0), 32'd0);
        i_Ready = 1'b1;
        wait_cycles(1);
        check("replace consumed", 32'(o_Valid), 32'd0);

        // Randomized frames against the frame-level model.
        rand_base = got_q.size();
        f0 = ferr_cnt; o0 = ovr_cnt;
        exp_ferr = 0;
        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, stop);
            if (stop) exp_q.push_back(d);
            else exp_ferr++;
            n = $urandom_range(stop ? 0 : 1, 6);
            if (n > 0) begin
                i_RX = 1'b1;
                wait_cycles(n);
            end
        end
        i_RX = 1'b1;
        wait_cycles(4 * CPB);
        check("random byte count", 32'(got_q.size() - rand_base), 32'(exp_q.size()));
        check("random frame errors", 32'(ferr_cnt - f0), 32'(exp_ferr));
        check("random overruns", 32'(ovr_cnt - o0), 32'd0);
        for (int j = 0; j < exp_q.size() && rand_base + j < got_q.size(); j++)
            check($sformatf("random byte %0d", j), 32'(got_q[rand_base + j]), 32'(exp_q[j]));

        // Reset during DATA bit 4 of 0xFF with a byte still pending.
        i_Ready = 1'b0;
        send_frame(8'h77, 1'b1);
        i_RX = 1'b1;
        wait_cycles(2 * CPB);
        check("pre-reset pending", 32'(o_Valid), 32'd1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        i_RX = 1'b1;
        wait_cycles(2);
        check("pre-reset busy", 32'(o_Busy), 32'd1);
        i_Rst = 1'b1;
        #1;
        check("mid-frame reset o_Valid",    32'(o_Valid),    32'd0);
        check("mid-frame reset o_Data",     32'(o_Data),     32'd0);
        check("mid-frame reset o_Busy",     32'(o_Busy),     32'd0);
        check("mid-frame reset o_FrameErr", 32'(o_FrameErr), 32'd0);
        check("mid-frame reset o_Overrun",  32'(o_Overrun),  32'd0);
        wait_cycles(3);
        i_Rst   = 1'b0;
        i_Ready = 1'b1;
        h0 = hs_cnt;
        wait_cycles(6 * CPB);
        check("post-reset remainder no valid", 32'(hs_cnt - h0), 32'd0);
        check("post-reset idle", 32'(o_Busy), 32'd0);
        send_frame(8'h5A, 1'b1);
        i_RX = 1'b1;
        wait_cycles(3 * CPB);
        check("post-reset byte count", 32'(hs_cnt - h0), 32'd1);
        check("post-reset byte", 32'(last_hs), 32'h5A);

        // Reset released while the line is low mid-frame: no phantom byte.
        h0 = hs_cnt;
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        i_Rst = 1'b1;
        wait_cycles(2);
        i_Rst = 1'b0;
        wait_cycles(4 * CPB);
        i_RX = 1'b1;
        wait_cycles(12 * CPB);
        check("low-line reset no valid", 32'(hs_cnt - h0), 32'd0);
        check("low-line reset idle", 32'(o_Busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
